// File: rtl/btn_incdec.sv
// Two-button debounced inc/dec front end with lockout.
// BTN_AUTO_REPEAT_EN enables hold-to-repeat; undefined gives one pulse per press.
module btn_incdec #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  output logic inc,
  output logic dec,
  output logic locked
);

  localparam int DW =
    (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST =
    DW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 1 || REP_DELAY < 2 || REP_PERIOD < 1)
  begin : g_bad_param
    $error("btn_incdec: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    LOCK
  } state_t;

  // bit 0 = up, bit 1 = down
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    db;
  logic [DW-1:0] dc [2];
  logic          db_up;
  logic          db_dn;

  state_t state;
  state_t state_nxt;
  logic   inc_nxt;
  logic   dec_nxt;

  assign db_up = db[0];
  assign db_dn = db[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      db    <= '0;
      dc[0] <= '0;
      dc[1] <= '0;
    end else begin
      s1 <= {btn_dn, btn_up};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DEB_LAST) begin
          db[i] <= ~db[i];
          dc[i] <= '0;
        end else begin
          dc[i] <= dc[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int TMAX =
    (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] T_DELAY =
    TW'(REP_DELAY - 1);
  localparam logic [TW-1:0] T_PERIOD =
    TW'(REP_PERIOD - 1);

  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else begin
      timer <= timer_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    inc_nxt   = 1'b0;
    dec_nxt   = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    timer_nxt = timer;
`endif
    unique case (state)
      IDLE: begin
        if (db_up && db_dn) begin
          state_nxt = LOCK;
        end else if (db_up) begin
          inc_nxt   = 1'b1;
          state_nxt = HOLD_UP;
`ifdef BTN_AUTO_REPEAT_EN
          timer_nxt = T_DELAY;
`endif
        end else if (db_dn) begin
          dec_nxt   = 1'b1;
          state_nxt = HOLD_DN;
`ifdef BTN_AUTO_REPEAT_EN
          timer_nxt = T_DELAY;
`endif
        end
      end
      HOLD_UP: begin
        if (db_dn) begin
          state_nxt = LOCK;
        end else if (!db_up) begin
          state_nxt = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (timer == '0) begin
          inc_nxt   = 1'b1;
          timer_nxt = T_PERIOD;
        end else begin
          timer_nxt = timer - 1'b1;
`endif
        end
      end
      HOLD_DN: begin
        if (db_up) begin
          state_nxt = LOCK;
        end else if (!db_dn) begin
          state_nxt = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (timer == '0) begin
          dec_nxt   = 1'b1;
          timer_nxt = T_PERIOD;
        end else begin
          timer_nxt = timer - 1'b1;
`endif
        end
      end
      LOCK: begin
        if (!db_up && !db_dn) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      inc    <= 1'b0;
      dec    <= 1'b0;
      locked <= 1'b0;
    end else begin
      state  <= state_nxt;
      inc    <= inc_nxt;
      dec    <= dec_nxt;
      locked <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_btn_incdec.sv
// Directed bench for btn_incdec (DEB=4, REP_DELAY=10, REP_PERIOD=3).
// Edge k counts posedges after the stimulus set-up point.
module tb_btn_incdec;

  logic clk;
  logic rst_n;
  logic btn_up;
  logic btn_dn;
  logic inc;
  logic dec;
  logic locked;

  int checks;
  int errors;

  int n_inc;
  int n_dec;
  int n_wide;
  int n_both;
  logic p_inc;
  logic p_dec;

  btn_incdec #(
    .DEB_CYCLES(4),
    .REP_DELAY (10),
    .REP_PERIOD(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .inc   (inc),
    .dec   (dec),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_inc = 0;
    n_dec = 0;
    n_wide = 0;
    n_both = 0;
    p_inc = 1'b0;
    p_dec = 1'b0;
  end

  always @(negedge clk) begin
    if (inc === 1'b1) n_inc++;
    if (dec === 1'b1) n_dec++;
    if (inc === 1'b1 && p_inc === 1'b1) n_wide++;
    if (dec === 1'b1 && p_dec === 1'b1) n_wide++;
    if (inc === 1'b1 && dec === 1'b1) n_both++;
    p_inc = inc;
    p_dec = dec;
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    #12;
    checks++;
    if ({inc, dec, locked} !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold got %b exp 000",
               {inc, dec, locked});
    end
    edge1();
    rst_n = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      edge1();
      checks++;
      if ({inc, dec, locked} !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle k=%0d got %b exp 000",
                 k, {inc, dec, locked});
      end
    end
  endtask

  task automatic test_press();
    int i0;
    do_reset();
    i0 = n_inc;
    btn_up = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      edge1();
      checks++;
      if (inc !== (k == 7)) begin
        errors++;
        $display("FAIL press_inc k=%0d got %b exp %b",
                 k, inc, (k == 7));
      end
      checks++;
      if (dec !== 1'b0) begin
        errors++;
        $display("FAIL press_dec k=%0d got %b exp 0",
                 k, dec);
      end
      if (k == 9) btn_up = 1'b0;
    end
    checks++;
    if (n_inc - i0 !== 1) begin
      errors++;
      $display("FAIL press_count got %0d exp 1",
               n_inc - i0);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      btn_dn = (k <= 30) && ((k / 2) % 2 == 0);
      edge1();
      checks++;
      if (dec !== 1'b0 || dut.db_dn !== 1'b0) begin
        errors++;
        $display("FAIL bounce k=%0d dec %b db %b exp 0 0",
                 k, dec, dut.db_dn);
      end
    end
  endtask

`ifdef BTN_AUTO_REPEAT_EN
  task automatic test_repeat();
    int  i0;
    int  w0;
    logic e;
    do_reset();
    i0 = n_inc;
    w0 = n_wide + n_both;
    btn_up = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      edge1();
      e = (k == 7) ||
          (k >= 17 && k <= 47 && (k - 17) % 3 == 0);
      checks++;
      if (inc !== e || dec !== 1'b0) begin
        errors++;
        $display("FAIL repeat k=%0d inc %b dec %b exp %b 0",
                 k, inc, dec, e);
      end
      if (k == 43) btn_up = 1'b0;
    end
    checks++;
    if (n_inc - i0 !== 12) begin
      errors++;
      $display("FAIL repeat_count got %0d exp 12",
               n_inc - i0);
    end
    checks++;
    if (n_wide + n_both !== w0) begin
      errors++;
      $display("FAIL repeat_shape got %0d exp %0d",
               n_wide + n_both, w0);
    end
  endtask
`else
  task automatic test_single();
    int d0;
    do_reset();
    d0 = n_dec;
    btn_dn = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      edge1();
      checks++;
      if (dec !== (k == 7) || inc !== 1'b0) begin
        errors++;
        $display("FAIL single k=%0d dec %b inc %b exp %b 0",
                 k, dec, inc, (k == 7));
      end
      if (k == 100) btn_dn = 1'b0;
    end
    checks++;
    if (n_dec - d0 !== 1) begin
      errors++;
      $display("FAIL single_count got %0d exp 1",
               n_dec - d0);
    end
  endtask
`endif

  task automatic test_lock();
    logic el;
    do_reset();
    btn_up = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      edge1();
      el = (k >= 15 && k <= 41);
      checks++;
      if (locked !== el) begin
        errors++;
        $display("FAIL lock k=%0d got %b exp %b",
                 k, locked, el);
      end
      checks++;
      if (inc !== (k == 7) || dec !== 1'b0) begin
        errors++;
        $display("FAIL lock_pulse k=%0d inc %b dec %b",
                 k, inc, dec);
      end
      if (k == 8)  btn_dn = 1'b1;
      if (k == 20) btn_up = 1'b0;
      if (k == 35) btn_dn = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
`ifdef BTN_AUTO_REPEAT_EN
    localparam int RK = 17;
`else
    localparam int RK = 7;
`endif
    do_reset();
    btn_up = 1'b1;
    for (int k = 1; k <= RK; k++) edge1();
    checks++;
    if (inc !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre got %b exp 1", inc);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inc, dec, locked} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_async got %b exp 000",
               {inc, dec, locked});
    end
    edge1();
    edge1();
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      checks++;
      if (inc !== (k == 7) || dec !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_post k=%0d inc %b exp %b",
                 k, inc, (k == 7));
      end
    end
    btn_up = 1'b0;
    repeat (12) edge1();
  endtask

  task automatic test_invariants();
    checks++;
    if (n_wide !== 0 || n_both !== 0) begin
      errors++;
      $display("FAIL invariants wide %0d both %0d exp 0 0",
               n_wide, n_both);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    test_reset();
    test_press();
    test_bounce();
`ifdef BTN_AUTO_REPEAT_EN
    test_repeat();
`else
    test_single();
`endif
    test_lock();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
